// File: rtl/csr_trap_ctrl.sv
// Purpose: sequences committed ecall / mret / CSR-write instructions into CSR-file strobes, pipeline flush and fetch redirect.
// Latency: one cycle from commit acceptance to strobe; a trap or return adds one more cycle before the redirect is offered.
// Backpressure: accepts a commit only in IDLE (cmt_ready); the redirect holds until redir_ready, stalling further commits.
//
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   cmt_valid/cmt_ready              commit handshake; cmt_pc, cmt_ecall, cmt_mret, cmt_csr_wen,
//                                    cmt_csr_addr, cmt_csr_wdata describe the committed instruction
//   csr_wen/csr_ecall/csr_mret       single-cycle strobes to the CSR file, with csr_pc/csr_waddr/csr_wdata
//   csr_mtvec/csr_mepc               CSR file outputs, sampled while csr_ecall/csr_mret is high
//   redir_valid/redir_ready/redir_pc fetch redirect handshake
//   flush, wr_err, trap_cnt          flush pulse, illegal-write pulse, saturating ecall count
module csr_trap_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmt_valid,
    output logic             cmt_ready,
    input  logic [PC_W-1:0]  cmt_pc,
    input  logic             cmt_ecall,
    input  logic             cmt_mret,
    input  logic             cmt_csr_wen,
    input  logic [11:0]      cmt_csr_addr,
    input  logic [PC_W-1:0]  cmt_csr_wdata,
    output logic             csr_wen,
    output logic             csr_ecall,
    output logic             csr_mret,
    output logic [PC_W-1:0]  csr_pc,
    output logic [11:0]      csr_waddr,
    output logic [PC_W-1:0]  csr_wdata,
    input  logic [PC_W-1:0]  csr_mtvec,
    input  logic [PC_W-1:0]  csr_mepc,
    output logic             redir_valid,
    output logic [PC_W-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic             wr_err,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        TRAP  = 3'd2,
        RET   = 3'd3,
        REDIR = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0] cap_pc;
    logic [11:0]     cap_addr;
    logic [PC_W-1:0] cap_wdata;
    logic            accept;
    logic            addr_ro;

    // Held low for the whole reset cycle even though the state register already reads IDLE.
    assign cmt_ready = (state == IDLE) && !reset;
    assign accept    = cmt_valid && cmt_ready;

    // CSR addresses with [11:10] == 2'b11 are the read-only space.
    assign addr_ro   = (cap_addr[11:10] == 2'b11);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmt_ecall)        state_nxt = TRAP;
                    else if (cmt_mret)    state_nxt = RET;
                    else if (cmt_csr_wen) state_nxt = WR;
                    else                  state_nxt = IDLE;
                end
            end
            WR:      state_nxt = IDLE;
            TRAP:    state_nxt = REDIR;
            RET:     state_nxt = REDIR;
            REDIR:   if (redir_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cap_pc    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            redir_pc  <= '0;
            trap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_pc    <= cmt_pc;
                cap_addr  <= cmt_csr_addr;
                cap_wdata <= cmt_csr_wdata;
            end
            if (state == TRAP) begin
                redir_pc <= csr_mtvec;
                if (trap_cnt != {CNT_W{1'b1}})
                    trap_cnt <= trap_cnt + CNT_W'(1);
            end
            if (state == RET)
                redir_pc <= csr_mepc;
        end
    end

    // Outputs depend only on state and captured registers; operand buses are zeroed when their strobe is low.
    always_comb begin
        csr_wen     = (state == WR) && !addr_ro;
        wr_err      = (state == WR) && addr_ro;
        csr_ecall   = (state == TRAP);
        csr_mret    = (state == RET);
        flush       = (state == TRAP) || (state == RET);
        redir_valid = (state == REDIR);
        csr_waddr   = csr_wen   ? cap_addr  : '0;
        csr_wdata   = csr_wen   ? cap_wdata : '0;
        csr_pc      = csr_ecall ? cap_pc    : '0;
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Purpose: directed self-checking bench for csr_trap_ctrl (main instance plus a 2-bit counter instance for saturation).
// Latency: inputs driven 1 time unit after each rising edge, outputs observed at the same point.
// Backpressure: redir_ready driven explicitly per vector; every run is a fixed number of cycles.
module tb_csr_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [31:0] cmt_pc;
    logic        cmt_ecall;
    logic        cmt_mret;
    logic        cmt_csr_wen;
    logic [11:0] cmt_csr_addr;
    logic [31:0] cmt_csr_wdata;
    logic        csr_wen;
    logic        csr_ecall;
    logic        csr_mret;
    logic [31:0] csr_pc;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        flush;
    logic        wr_err;
    logic [15:0] trap_cnt;

    // Small-counter instance sharing all inputs.
    logic        s_cmt_ready;
    logic        s_csr_wen;
    logic        s_csr_ecall;
    logic        s_csr_mret;
    logic [31:0] s_csr_pc;
    logic [11:0] s_csr_waddr;
    logic [31:0] s_csr_wdata;
    logic        s_redir_valid;
    logic [31:0] s_redir_pc;
    logic        s_flush;
    logic        s_wr_err;
    logic [1:0]  s_trap_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    csr_trap_ctrl #(.PC_W(32), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
        .cmt_ecall(cmt_ecall), .cmt_mret(cmt_mret), .cmt_csr_wen(cmt_csr_wen),
        .cmt_csr_addr(cmt_csr_addr), .cmt_csr_wdata(cmt_csr_wdata),
        .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_mret(csr_mret),
        .csr_pc(csr_pc), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .wr_err(wr_err), .trap_cnt(trap_cnt)
    );

    csr_trap_ctrl #(.PC_W(32), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .cmt_valid(cmt_valid), .cmt_ready(s_cmt_ready), .cmt_pc(cmt_pc),
        .cmt_ecall(cmt_ecall), .cmt_mret(cmt_mret), .cmt_csr_wen(cmt_csr_wen),
        .cmt_csr_addr(cmt_csr_addr), .cmt_csr_wdata(cmt_csr_wdata),
        .csr_wen(s_csr_wen), .csr_ecall(s_csr_ecall), .csr_mret(s_csr_mret),
        .csr_pc(s_csr_pc), .csr_waddr(s_csr_waddr), .csr_wdata(s_csr_wdata),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .redir_ready(redir_ready),
        .flush(s_flush), .wr_err(s_wr_err), .trap_cnt(s_trap_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cmt();
        cmt_valid     = 1'b0;
        cmt_ecall     = 1'b0;
        cmt_mret      = 1'b0;
        cmt_csr_wen   = 1'b0;
        cmt_pc        = '0;
        cmt_csr_addr  = '0;
        cmt_csr_wdata = '0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic e, input logic m, input logic w,
                          input logic [11:0] addr, input logic [31:0] data);
        cmt_valid     = 1'b1;
        cmt_pc        = pc;
        cmt_ecall     = e;
        cmt_mret      = m;
        cmt_csr_wen   = w;
        cmt_csr_addr  = addr;
        cmt_csr_wdata = data;
    endtask

    initial begin
        reset       = 1'b1;
        redir_ready = 1'b0;
        csr_mtvec   = 32'h8000_0100;
        csr_mepc    = 32'h8000_0010;
        idle_cmt();

        // Reset state
        step();
        step();
        chk("rst_ready",  cmt_ready,   0);
        chk("rst_rvalid", redir_valid, 0);
        chk("rst_cnt",    trap_cnt,    0);
        chk("rst_rpc",    redir_pc,    0);
        chk("rst_strobe", {csr_wen, csr_ecall, csr_mret, flush, wr_err}, 0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", cmt_ready, 1);

        // CSR write 0x305
        commit(32'h0, 1'b0, 1'b0, 1'b1, 12'h305, 32'h8000_0000);
        step();
        idle_cmt();
        chk("wr_wen",   csr_wen,   1);
        chk("wr_addr",  csr_waddr, 12'h305);
        chk("wr_data",  csr_wdata, 32'h8000_0000);
        chk("wr_ready", cmt_ready, 0);
        chk("wr_err0",  wr_err,    0);
        step();
        chk("wr_done_wen",   csr_wen,   0);
        chk("wr_done_addr",  csr_waddr, 0);
        chk("wr_done_data",  csr_wdata, 0);
        chk("wr_done_ready", cmt_ready, 1);

        // ecall with 3-cycle redirect stall
        commit(32'h8000_0010, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        step();
        idle_cmt();
        chk("trap_ecall", csr_ecall,   1);
        chk("trap_flush", flush,       1);
        chk("trap_pc",    csr_pc,      32'h8000_0010);
        chk("trap_rv",    redir_valid, 0);
        chk("trap_cnt0",  trap_cnt,    0);
        step();
        chk("redir1_v",     redir_valid, 1);
        chk("redir1_pc",    redir_pc,    32'h8000_0100);
        chk("redir1_cnt",   trap_cnt,    1);
        chk("redir1_ecall", csr_ecall,   0);
        chk("redir1_pcz",   csr_pc,      0);
        chk("redir1_flush", flush,       0);
        step();
        chk("redir2_v",  redir_valid, 1);
        chk("redir2_pc", redir_pc,    32'h8000_0100);
        step();
        chk("redir3_v",  redir_valid, 1);
        chk("redir3_rdy", cmt_ready,  0);
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        chk("trap_idle_v",   redir_valid, 0);
        chk("trap_idle_rdy", cmt_ready,   1);

        // mret with redir_ready held high throughout
        commit(32'h0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
        redir_ready = 1'b1;
        step();
        idle_cmt();
        chk("ret_mret",  csr_mret,    1);
        chk("ret_flush", flush,       1);
        chk("ret_rv",    redir_valid, 0);
        chk("ret_pcz",   csr_pc,      0);
        step();
        chk("ret_redir_v",  redir_valid, 1);
        chk("ret_redir_pc", redir_pc,    32'h8000_0010);
        chk("ret_mret_off", csr_mret,    0);
        step();
        chk("ret_idle_rdy", cmt_ready,   1);
        chk("ret_idle_v",   redir_valid, 0);
        chk("ret_cnt",      trap_cnt,    1);
        // redir_ready still high while idle: must not matter
        step();
        chk("idle_rdy_ign", redir_valid, 0);
        redir_ready = 1'b0;

        // all flags set: ecall wins
        commit(32'h8000_0020, 1'b1, 1'b1, 1'b1, 12'h305, 32'h1234_5678);
        step();
        idle_cmt();
        chk("prio_ecall", csr_ecall, 1);
        chk("prio_mret",  csr_mret,  0);
        chk("prio_wen",   csr_wen,   0);
        chk("prio_pc",    csr_pc,    32'h8000_0020);
        step();
        chk("prio_cnt", trap_cnt, 2);
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;

        // read-only write 0xF11
        commit(32'h0, 1'b0, 1'b0, 1'b1, 12'hF11, 32'hDEAD_BEEF);
        step();
        idle_cmt();
        chk("ro_err",  wr_err,    1);
        chk("ro_wen",  csr_wen,   0);
        chk("ro_addr", csr_waddr, 0);
        step();
        chk("ro_err_off", wr_err, 0);

        // no-flag commit is absorbed in one cycle, back-to-back with a write
        commit(32'h0, 1'b0, 1'b0, 1'b0, 12'h305, 32'h5);
        step();
        chk("nop_ready",  cmt_ready, 1);
        chk("nop_strobe", {csr_wen, csr_ecall, csr_mret, flush, wr_err}, 0);
        commit(32'h0, 1'b0, 1'b0, 1'b1, 12'h340, 32'hA5A5_0001);
        step();
        idle_cmt();
        chk("b2b_wen",  csr_wen,   1);
        chk("b2b_addr", csr_waddr, 12'h340);
        chk("b2b_data", csr_wdata, 32'hA5A5_0001);
        step();

        // reset in the middle of a redirect
        commit(32'h8000_0030, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        step();
        idle_cmt();
        step();
        chk("mid_redir_v", redir_valid, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_v",   redir_valid, 0);
        chk("mid_rst_cnt", trap_cnt,    0);
        chk("mid_rst_rpc", redir_pc,    0);
        chk("mid_rst_rdy", cmt_ready,   0);
        reset = 1'b0;
        step();
        chk("mid_rel_rdy", cmt_ready,   1);
        chk("mid_rel_v",   redir_valid, 0);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            commit(32'h8000_0040, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
            step();
            idle_cmt();
            step();
            chk("sat_cnt16", trap_cnt,   16'(i + 1));
            chk("sat_cnt2",  s_trap_cnt, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
            redir_ready = 1'b1;
            step();
            redir_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
